compare_4bit: RTL and testbench

COMPARE_4BIT -- requirements
Module: compare_4bit

---
 rtl/compare_4bit_pkg.sv | 8 +
 rtl/compare_4bit_core.sv | 18 +
 rtl/compare_4bit.sv | 54 +++++
 tb/tb_compare_4bit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/compare_4bit_pkg.sv
// Shared constants for the registered 4-bit magnitude comparator.
// Holds the operand width and the default match-counter width.
package compare_4bit_pkg;

    localparam int OP_W          = 4;
    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/compare_4bit_core.sv
// Purely combinational unsigned 4-bit comparator.
// Exactly one of eq/gt/lt is high for any fully known input pair.
module cmp4_core
    import compare_4bit_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic            eq,
    output logic            gt,
    output logic            lt
);

    // Operands are declared unsigned, so 4'hF compares greater than 4'h0.
    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/compare_4bit.sv
// Registered comparator top: one-cycle-latency flags, an equal rising-edge
// pulse and a saturating count of equal samples.
module compare_4bit
    import compare_4bit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic             equal,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             eq_rise,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic eq_c;
    logic gt_c;
    logic lt_c;

    cmp4_core u_core (
        .a  (A),
        .b  (B),
        .eq (eq_c),
        .gt (gt_c),
        .lt (lt_c)
    );

    // NOTE: non-blocking assignments let eq_rise read the previous equal value
    // in the same edge that equal is being updated.
    always_ff @(posedge clk) begin
        if (rst) begin
            equal     <= 1'b0;
            a_gt_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            eq_rise   <= 1'b0;
            match_cnt <= '0;
        end else begin
            equal   <= eq_c;
            a_gt_b  <= gt_c;
            a_lt_b  <= lt_c;
            eq_rise <= eq_c & ~equal;
            // Hold at all-ones instead of wrapping back to zero.
            if (eq_c && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_compare_4bit.sv
// Directed self-checking bench for compare_4bit: reset, sweeps, alternation,
// saturation, mid-count reset and an exhaustive flag check.
module tb_compare_4bit;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [3:0]       A;
    logic [3:0]       B;
    logic             equal;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             eq_rise;
    logic [CNT_W-1:0] match_cnt;

    int tests_run;
    int tests_failed;

    compare_4bit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .equal     (equal),
        .a_gt_b    (a_gt_b),
        .a_lt_b    (a_lt_b),
        .eq_rise   (eq_rise),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after an edge; outputs are read 1 unit after the next.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b);
        A = a;
        B = b;
        tick();
    endtask

    task automatic do_reset(input logic [3:0] a, input logic [3:0] b);
        rst = 1'b1;
        apply(a, b);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(4'h5, 4'h5);
        tests_run++;
        if ({equal, a_gt_b, a_lt_b, eq_rise, match_cnt} !== '0) begin
            tests_failed++;
            $display("FAIL reset: got eq=%b gt=%b lt=%b rise=%b cnt=%0d, want all 0",
                     equal, a_gt_b, a_lt_b, eq_rise, match_cnt);
        end
    endtask

    task automatic test_first_gt();
        apply(4'h1, 4'h0);
        tests_run++;
        if ({equal, a_gt_b, a_lt_b, eq_rise} !== 4'b0100 || match_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL first_gt: got eq=%b gt=%b lt=%b rise=%b cnt=%0d, want 0 1 0 0 cnt=0",
                     equal, a_gt_b, a_lt_b, eq_rise, match_cnt);
        end
    endtask

    task automatic test_sweep_b();
        logic [3:0] exp_flags;
        logic [7:0] exp_cnt;
        do_reset(4'h1, 4'h0);
        for (int b = 0; b < 16; b++) begin
            apply(4'h1, 4'(b));
            // {equal, a_gt_b, a_lt_b, eq_rise}
            exp_flags = (b == 0) ? 4'b0100 : (b == 1) ? 4'b1001 : 4'b0010;
            exp_cnt   = (b >= 1) ? 8'd1 : 8'd0;
            tests_run++;
            if ({equal, a_gt_b, a_lt_b, eq_rise} !== exp_flags || match_cnt !== exp_cnt) begin
                tests_failed++;
                $display("FAIL sweep_b b=%0d: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                         b, {equal, a_gt_b, a_lt_b, eq_rise}, match_cnt, exp_flags, exp_cnt);
            end
        end
    endtask

    task automatic test_alternate();
        do_reset(4'h1, 4'h0);
        for (int i = 1; i <= 14; i++) begin
            // A still holds i from the previous step, so B=i makes them equal.
            apply(4'(i), 4'(i));
            tests_run++;
            if ({equal, a_gt_b, a_lt_b, eq_rise} !== 4'b1001 || match_cnt !== 8'(i)) begin
                tests_failed++;
                $display("FAIL alternate_eq i=%0d: got flags=%b cnt=%0d, want flags=1001 cnt=%0d",
                         i, {equal, a_gt_b, a_lt_b, eq_rise}, match_cnt, i);
            end
            apply(4'(i + 1), 4'(i));
            tests_run++;
            if ({equal, a_gt_b, a_lt_b, eq_rise} !== 4'b0100 || match_cnt !== 8'(i)) begin
                tests_failed++;
                $display("FAIL alternate_gt i=%0d: got flags=%b cnt=%0d, want flags=0100 cnt=%0d",
                         i, {equal, a_gt_b, a_lt_b, eq_rise}, match_cnt, i);
            end
        end
    endtask

    task automatic test_saturate();
        int rises;
        int exp_cnt;
        rises = 0;
        do_reset(4'h0, 4'h1);
        for (int n = 1; n <= 300; n++) begin
            apply(4'hF, 4'hF);
            exp_cnt = (n < 255) ? n : 255;
            if (eq_rise === 1'b1) rises++;
            tests_run++;
            if (match_cnt !== 8'(exp_cnt) || equal !== 1'b1 || eq_rise !== (n == 1)) begin
                tests_failed++;
                $display("FAIL saturate n=%0d: got cnt=%0d eq=%b rise=%b, want cnt=%0d eq=1 rise=%b",
                         n, match_cnt, equal, eq_rise, exp_cnt, (n == 1));
            end
        end
        tests_run++;
        if (rises !== 1) begin
            tests_failed++;
            $display("FAIL saturate_rises: got %0d pulses, want 1", rises);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(4'h0, 4'h1);
        for (int n = 0; n < 37; n++) apply(4'h3, 4'h3);
        tests_run++;
        if (match_cnt !== 8'd37 || equal !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got cnt=%0d eq=%b, want cnt=37 eq=1", match_cnt, equal);
        end
        do_reset(4'h3, 4'h3);
        tests_run++;
        if ({equal, a_gt_b, a_lt_b, eq_rise, match_cnt} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear: got flags=%b cnt=%0d, want all 0",
                     {equal, a_gt_b, a_lt_b, eq_rise}, match_cnt);
        end
        apply(4'h3, 4'h3);
        tests_run++;
        if ({equal, a_gt_b, a_lt_b, eq_rise} !== 4'b1001 || match_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: got flags=%b cnt=%0d, want flags=1001 cnt=1",
                     {equal, a_gt_b, a_lt_b, eq_rise}, match_cnt);
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] exp_flags;
        int errs;
        errs = 0;
        do_reset(4'h0, 4'h0);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                apply(4'(a), 4'(b));
                // {equal, a_gt_b, a_lt_b}
                exp_flags = (a == b) ? 3'b100 : (a > b) ? 3'b010 : 3'b001;
                tests_run++;
                if ({equal, a_gt_b, a_lt_b} !== exp_flags) begin
                    tests_failed++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL exhaustive a=%0d b=%0d: got %b, want %b",
                                 a, b, {equal, a_gt_b, a_lt_b}, exp_flags);
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        A   = 4'h0;
        B   = 4'h0;
        tick();
        test_reset();
        test_first_gt();
        test_sweep_b();
        test_alternate();
        test_saturate();
        test_reset_mid();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
